// File: rtl/add_feeder.sv
// add_feeder: buffers operand pairs in a small FIFO and presents the head
// pair to an external adder. The returned sum is registered with a locally
// computed carry-out. The sum is cross-checked against an internal reference,
// and mismatches are counted.
module add_feeder #(
  parameter int C_WIDTH = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C_WIDTH-1:0] in_a,
  input  logic [C_WIDTH-1:0] in_b,
  output logic [C_WIDTH-1:0] add_a,
  output logic [C_WIDTH-1:0] add_b,
  input  logic [C_WIDTH-1:0] add_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C_WIDTH-1:0] out_c,
  output logic               out_ovf,
  output logic [4:0]         fifo_cnt,
  output logic               err,
  output logic [7:0]         err_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  // Full-width reference sum; the top bit is the carry-out.
  function automatic logic [C_WIDTH:0] ref_sum(input logic [C_WIDTH-1:0] a,
                                               input logic [C_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [2*C_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [4:0]           cnt_r;
  logic                 out_valid_r;
  logic [C_WIDTH-1:0]   out_c_r;
  logic                 out_ovf_r;
  logic                 err_r;
  logic [7:0]           err_cnt_r;

  logic                 not_empty_s;
  logic                 push_s;
  logic                 load_s;
  logic [2*C_WIDTH-1:0] head_s;
  logic [C_WIDTH-1:0]   head_a_s;
  logic [C_WIDTH-1:0]   head_b_s;
  logic [C_WIDTH:0]     sum_s;
  logic                 mismatch_s;

  assign not_empty_s = (cnt_r != 5'd0);
  assign in_ready    = (cnt_r < DEPTH_C);
  assign push_s      = in_valid && in_ready;
  assign load_s      = not_empty_s && (!out_valid_r || out_ready);
  assign head_s      = mem_r[rd_ptr_r];
  assign head_a_s    = head_s[2*C_WIDTH-1:C_WIDTH];
  assign head_b_s    = head_s[C_WIDTH-1:0];
  assign sum_s       = ref_sum(head_a_s, head_b_s);
  assign mismatch_s  = (add_c != sum_s[C_WIDTH-1:0]);

  assign out_valid = out_valid_r;
  assign out_c     = out_c_r;
  assign out_ovf   = out_ovf_r;
  assign fifo_cnt  = cnt_r;
  assign err       = err_r;
  assign err_cnt   = err_cnt_r;

  // Present the head pair to the adder, or zeros when nothing is queued.
  always_comb begin
    add_a = {C_WIDTH{1'b0}};
    add_b = {C_WIDTH{1'b0}};
    if (not_empty_s) begin
      add_a = head_a_s;
      add_b = head_b_s;
    end else begin
      add_a = {C_WIDTH{1'b0}};
      add_b = {C_WIDTH{1'b0}};
    end
  end

  // Operand storage; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_a, in_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= 5'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, load_s})
        2'b10:   cnt_r <= cnt_r + 5'd1;
        2'b01:   cnt_r <= cnt_r - 5'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Result register: load from the adder on pop, drop once consumed, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_c_r     <= {C_WIDTH{1'b0}};
      out_ovf_r   <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_c_r     <= add_c;
      out_ovf_r   <= sum_s[C_WIDTH];
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky error flag and saturating mismatch counter, evaluated on each load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r     <= 1'b0;
      err_cnt_r <= 8'd0;
    end else if (load_s && mismatch_s) begin
      err_r <= 1'b1;
      if (err_cnt_r != 8'hFF) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_add_feeder.sv
// Scoreboard bench for add_feeder: the bench plays the downstream adder
// (optionally off by one) and predicts each result from the accepted pairs.
module tb_add_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [7:0] add_a, add_b, add_c;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_c;
  logic       out_ovf;
  logic [4:0] fifo_cnt;
  logic       err;
  logic [7:0] err_cnt;
  logic       corrupt = 1'b0;

  typedef struct {
    int a;
    int b;
    int bad;
  } pair_t;

  pair_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int popped = 0;
  int accepted = 0;
  int n_corrupt = 0;

  add_feeder #(.C_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_ovf(out_ovf), .fifo_cnt(fifo_cnt), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Bench-side adder, optionally returning a wrong sum.
  assign add_c = add_a + add_b + {7'd0, corrupt};

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus; records accepted pairs and checks occupancy.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
    pair_t p;
    in_valid = v;
    in_a = a;
    in_b = b;
    @(negedge clk);
    if (v && in_ready) begin
      p.a = int'(a);
      p.b = int'(b);
      p.bad = corrupt ? 1 : 0;
      exp_q.push_back(p);
      accepted++;
      if (corrupt) n_corrupt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("fifo_cnt_vs_model", int'(fifo_cnt), exp_q.size() - int'(out_valid));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0) && (n < 200)) begin
      step(1'b0, 8'h00, 8'h00);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Monitor: every consumed result is compared with the oldest expectation.
  always @(negedge clk) begin
    pair_t e;
    int s;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got c=%0d with nothing expected", out_c);
      end else begin
        e = exp_q.pop_front();
        s = e.a + e.b;
        chk("out_c", int'(out_c), (s + e.bad) % 256);
        chk("out_ovf", int'(out_ovf), (s > 255) ? 1 : 0);
        popped++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, a0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_fifo_cnt", int'(fifo_cnt), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    chk("reset_add_a", int'(add_a), 0);
    rst_n = 1'b1;
    chk("reset_in_ready", int'(in_ready), 1);

    // FF + FF held in the result register
    out_ready = 1'b0;
    step(1'b1, 8'hFF, 8'hFF);
    step(1'b0, 8'h00, 8'h00);
    chk("ff_valid", int'(out_valid), 1);
    chk("ff_c", int'(out_c), 254);
    chk("ff_ovf", int'(out_ovf), 1);
    chk("ff_err", int'(err), 0);
    step(1'b0, 8'h00, 8'h00);
    chk("ff_hold_c", int'(out_c), 254);
    drain();

    // 00 + 01
    out_ready = 1'b0;
    step(1'b1, 8'h00, 8'h01);
    step(1'b0, 8'h00, 8'h00);
    chk("01_valid", int'(out_valid), 1);
    chk("01_c", int'(out_c), 1);
    chk("01_ovf", int'(out_ovf), 0);
    drain();

    // Backpressure: five accepted, sixth refused
    out_ready = 1'b0;
    a0 = accepted;
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 8'($urandom));
    chk("bp_accepted", accepted - a0, 5);
    chk("bp_fifo_cnt", int'(fifo_cnt), 4);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_out_valid", int'(out_valid), 1);
    drain();

    // Streaming 16 back-to-back pairs
    out_ready = 1'b1;
    a0 = accepted;
    p0 = popped;
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 8'($urandom));
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    chk("stream_accepted", accepted - a0, 16);
    chk("stream_results", popped - p0, 16);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom));
    end
    drain();
    chk("random_err", int'(err), 0);

    // Faulty adder: three mismatches, then saturation
    corrupt = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 8'($urandom));
    drain();
    chk("err_flag", int'(err), 1);
    chk("err_cnt_3", int'(err_cnt), n_corrupt);
    for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 8'($urandom));
    drain();
    chk("err_cnt_sat", int'(err_cnt), (n_corrupt > 255) ? 255 : n_corrupt);
    corrupt = 1'b0;

    // Reset mid-operation with a queued backlog and pending result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 8'($urandom));
    chk("pre_rst_cnt", int'(fifo_cnt), 3);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_fifo_cnt", int'(fifo_cnt), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h80, 8'h80);
    drain();
    chk("post_rst_err", int'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
